// File: rtl/piso_serializer.sv
// piso_serializer
// Parallel-in, serial-out word serializer feeding a downstream serial pattern
// detector. Words of WIDTH bits are accepted over a valid/ready handshake and
// shifted out one bit per clock. A one-word hold buffer lets consecutive words
// stream with no idle bit between them. The serial line idles at 0.
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   reset       synchronous, active-high reset
//   load_data   word to serialize (WIDTH bits)
//   load_valid  load_data is valid
//   load_ready  block can accept a word this cycle
//   out         serial bit (0 while idle)
//   out_valid   out carries a real data bit
//   last_bit    high together with the final bit of each word
//   busy        a shift is in progress or a word is held
//
// Handshake: a word is transferred at a rising edge where load_valid and
// load_ready are both high. load_ready depends only on registered state and
// reset, never on load_valid. The producer holds load_data stable while
// load_valid is high and may drop load_valid after any transfer edge.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] hbuf;
  logic [CW-1:0]    cnt;
  logic             hvalid;

  logic             accept;
  logic             cur_bit;
  logic [WIDTH-1:0] sreg_shifted;

  // A full hold buffer is the only back-pressure; reset also blocks transfers.
  assign load_ready = ~hvalid & ~reset;
  assign accept     = load_valid & load_ready;

  // The bit on the line is always the one at the output end of sreg; the
  // register moves toward that end once per emitted bit.
  always_comb begin
    if (MSB_FIRST) begin
      cur_bit      = sreg[WIDTH-1];
      sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
    end else begin
      cur_bit      = sreg[0];
      sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
    end
  end

  // Outputs are decoded from registers only, so load_* never reaches out.
  assign out_valid = (state == SHIFT);
  assign out       = out_valid & cur_bit;
  assign last_bit  = out_valid & (cnt == CNT_LAST);
  assign busy      = out_valid | hvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      sreg   <= '0;
      hbuf   <= '0;
      hvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= load_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != CNT_LAST) begin
            sreg <= sreg_shifted;
            cnt  <= cnt + CW'(1);
            if (accept) begin
              hbuf   <= load_data;
              hvalid <= 1'b1;
            end
          end else if (hvalid) begin
            // Held word follows immediately; load_ready was low, so no accept.
            sreg   <= hbuf;
            hvalid <= 1'b0;
            cnt    <= '0;
          end else if (accept) begin
            // Word offered on the last-bit cycle goes straight into sreg.
            sreg <= load_data;
            cnt  <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: an MSB-first and an LSB-first instance are
// driven with the same stimulus; expected bit streams are queued at each
// accepted word and compared as the DUTs emit them.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] load_data;
  logic       load_valid;
  logic       ready_m, out_m, ov_m, last_m, busy_m;
  logic       ready_l, out_l, ov_l, last_l, busy_l;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  typedef struct { logic b; logic l; } bit_t;
  bit_t q_m[$];
  bit_t q_l[$];

  // exp_msb / exp_lsb list the emitted stream with the first bit in bit 7.
  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready_m), .out(out_m), .out_valid(ov_m), .last_bit(last_m),
    .busy(busy_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready_l), .out(out_l), .out_valid(ov_l), .last_bit(last_l),
    .busy(busy_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: while expected bits are pending, the line must carry
  // them back to back; otherwise it must be idle at 0.
  always @(negedge clk) begin
    bit_t e;
    if (mon_en) begin
      if (q_m.size() != 0) begin
        e = q_m.pop_front();
        chk("m_valid", {31'd0, ov_m}, 32'd1);
        chk("m_bit", {31'd0, out_m}, {31'd0, e.b});
        chk("m_last", {31'd0, last_m}, {31'd0, e.l});
      end else begin
        chk("m_idle_valid", {31'd0, ov_m}, 32'd0);
        chk("m_idle_out", {31'd0, out_m}, 32'd0);
      end
      if (q_l.size() != 0) begin
        e = q_l.pop_front();
        chk("l_valid", {31'd0, ov_l}, 32'd1);
        chk("l_bit", {31'd0, out_l}, {31'd0, e.b});
        chk("l_last", {31'd0, last_l}, {31'd0, e.l});
      end else begin
        chk("l_idle_valid", {31'd0, ov_l}, 32'd0);
        chk("l_idle_out", {31'd0, out_l}, 32'd0);
      end
    end
  end

  task automatic push_word(input logic [7:0] em, input logic [7:0] el);
    bit_t e;
    for (int i = 0; i < 8; i++) begin
      e.b = em[7-i]; e.l = (i == 7); q_m.push_back(e);
      e.b = el[7-i]; e.l = (i == 7); q_l.push_back(e);
    end
  endtask

  // Offer a word now (called between edges); it transfers at the next edge.
  task automatic send_now(input logic [7:0] d, input logic [7:0] em, input logic [7:0] el);
    load_data  = d;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    push_word(em, el);
    load_valid = 1'b0;
  endtask

  // Wait (bounded) for load_ready at a falling edge, then offer the word.
  task automatic send(input logic [7:0] d, input logic [7:0] em, input logic [7:0] el);
    int n = 0;
    @(negedge clk);
    while (!ready_m && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'd1, 32'd0);
    send_now(d, em, el);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q_m.size() != 0 || q_l.size() != 0) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int pulses;
    int pulse_on_last;
    logic [2:0] hist;

    vecs[0] = '{8'hA5, 8'b10100101, 8'b10100101};
    vecs[1] = '{8'h01, 8'b00000001, 8'b10000000};
    vecs[2] = '{8'hF0, 8'b11110000, 8'b00001111};
    vecs[3] = '{8'h3C, 8'b00111100, 8'b00111100};
    vecs[4] = '{8'h81, 8'b10000001, 8'b10000001};
    vecs[5] = '{8'hC6, 8'b11000110, 8'b01100011};

    reset = 1'b1; load_valid = 1'b0; load_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("ready_in_reset", {31'd0, ready_m}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out", {31'd0, out_m}, 32'd0);
    chk("rst_valid", {31'd0, ov_m}, 32'd0);
    chk("rst_last", {31'd0, last_m}, 32'd0);
    chk("rst_busy", {31'd0, busy_m}, 32'd0);
    chk("rst_ready", {31'd0, ready_m}, 32'd1);
    mon_en = 1'b1;

    // Single words from the table, each fully drained before the next.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data, vecs[i].exp_msb, vecs[i].exp_lsb);
      wait_drain();
      @(negedge clk);
      chk("vec_busy_after", {31'd0, busy_m | busy_l}, 32'd0);
      chk("vec_ready_after", {31'd0, ready_m & ready_l}, 32'd1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Back-to-back through the hold buffer: second accept two edges later.
    send(8'hAA, 8'hAA, 8'h55);
    @(posedge clk);
    send(8'h55, 8'h55, 8'hAA);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_ready_low", {31'd0, ready_m | ready_l}, 32'd0);
      chk("b2b_busy", {31'd0, busy_m}, 32'd1);
    end
    @(negedge clk);
    chk("b2b_ready_back", {31'd0, ready_m & ready_l}, 32'd1);
    wait_drain();
    @(negedge clk);

    // Last-cycle bypass: offer the next word during the last-bit cycle.
    send(8'hF0, 8'hF0, 8'h0F);
    repeat (7) @(posedge clk);
    @(negedge clk);
    #1;
    chk("byp_last_bit", {31'd0, last_m}, 32'd1);
    chk("byp_ready", {31'd0, ready_m}, 32'd1);
    send_now(8'h0F, 8'h0F, 8'hF0);
    @(negedge clk);
    #1;
    chk("byp_bit9_valid", {31'd0, ov_m}, 32'd1);
    chk("byp_bit9", {31'd0, out_m}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      chk("byp_no_hold", {31'd0, ready_m & ready_l}, 32'd1);
      @(negedge clk);
      #1;
    end
    wait_drain();
    @(negedge clk);

    // Reset mid-word while the hold buffer is full.
    send(8'hFF, 8'hFF, 8'hFF);
    send(8'hAA, 8'hAA, 8'h55);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready_low", {31'd0, ready_m}, 32'd0);
    @(posedge clk);
    #1;
    q_m.delete();
    q_l.delete();
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_out", {31'd0, out_m | out_l}, 32'd0);
    chk("mid_rst_valid", {31'd0, ov_m | ov_l}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_m | busy_l}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready_m & ready_l}, 32'd1);
    repeat (20) @(negedge clk);

    // Serial 1010 detector model on the MSB-first stream of 8'h0A.
    pulses = 0; pulse_on_last = 0; hist = 3'b000;
    send(8'h0A, 8'h0A, 8'h50);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      #1;
      if ({hist, out_m} == 4'b1010) begin
        pulses++;
        if (last_m) pulse_on_last++;
      end
      hist = {hist[1:0], out_m};
    end
    chk("det_pulses", pulses, 32'd1);
    chk("det_on_last", pulse_on_last, 32'd1);

    wait_drain();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out word serializer that produces the single-bit stream consumed by the downstream serial pattern detector (1010 detector). It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock. A one-word holding buffer allows back-to-back words to stream with no idle bit between them. When no word is being shifted, the serial line idles at 0.

## Interface

Parameters:
- WIDTH, 8, word width in bits (≥ 2)
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first; 0 = bit 0 first

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- load_data  input  WIDTH  word to serialize
- load_valid  input  1  load_data is valid
- load_ready  output  1  block can accept a word this cycle
- out  output  1  serial bit; drives the detector's serial input
- out_valid  output  1  out carries a real data bit
- last_bit  output  1  high with the final bit of each word
- busy  output  1  shift in progress or a word is held

## Operation

- Accept event: load_valid & load_ready at a rising edge. There is no accept while reset is high.
- State: FSM {IDLE, SHIFT}, shift register sreg[WIDTH], bit counter cnt (0..WIDTH-1, width $clog2(WIDTH)), hold buffer hbuf[WIDTH] with flag hvalid.
- load_ready = ~hvalid & ~reset (combinational).
- IDLE behaviour:
  - out = 0, out_valid = 0, last_bit = 0.
  - hvalid is always 0 in IDLE.
  - On accept: sreg ← load_data, cnt ← 0, go to SHIFT.
- SHIFT behaviour:
  - out = current bit of sreg: sreg[WIDTH-1] if MSB_FIRST, else sreg[0].
  - out_valid = 1, and last_bit = (cnt == WIDTH-1).
  - At each edge with cnt < WIDTH-1: shift sreg toward the output end and cnt ← cnt+1.
  - At the same edge, an accept writes hbuf ← load_data and hvalid ← 1.
- End of word (edge with cnt == WIDTH-1), by priority:
  1. hvalid = 1: sreg ← hbuf, hvalid ← 0, cnt ← 0, stay in SHIFT.
  2. Else, on a same-cycle accept: sreg ← load_data (bypass hbuf), cnt ← 0, stay in SHIFT.
  3. Else: go to IDLE.
- Simultaneous events:
  - Accept cannot coincide with hvalid = 1, because load_ready is low.
  - An accept on the last-bit cycle with hbuf empty gives a gapless continuation.
- busy = (state == SHIFT) | hvalid.
- out, out_valid and last_bit are decoded from registered state only (no input-to-output combinational path).
- Reset (at any time, including mid-word):
  - state ← IDLE, cnt ← 0, sreg ← 0, hvalid ← 0.
  - Any partially shifted word and any held word are discarded.
- Outputs in the cycle after the reset edge: out = 0, out_valid = 0, last_bit = 0, busy = 0, load_ready = 1.

## Timing

- Latency: a word accepted at edge k presents its first bit during the cycle after edge k. Its last bit is presented during the cycle after edge k+WIDTH-1.
- Throughput: one word per WIDTH cycles. Zero bubble bits between words if hbuf is refilled before each last-bit edge, or the next word is offered in the last-bit cycle.
- load_ready falls the cycle after a hold-buffer write. It rises the cycle after the end-of-word edge that drains hbuf.
- The detector samples out on the same clk with no enable. Idle zeros are legitimate input to it; out_valid is for monitors only.

## Test plan

- **Single word MSB-first.**
  - Stimulus: WIDTH=8, accept 8'hA5 in IDLE.
  - Response: over the next 8 cycles out = 1,0,1,0,0,1,0,1 with out_valid = 1 and last_bit only on the 8th. Then out_valid = 0, out = 0, busy = 0.
- **Back-to-back.**
  - Stimulus: accept 8'hAA, then 8'h55 two cycles later.
  - Response: load_ready is low from the cycle after the second accept until the edge after bit 8. 16 contiguous valid bits: 1,0,1,0,1,0,1,0,0,1,0,1,0,1,0,1. last_bit on bits 8 and 16.
- **Last-cycle bypass.**
  - Stimulus: accept 8'hF0 with hbuf empty, then offer 8'h0F exactly in the last-bit cycle.
  - Response: no gap; the 9th bit is 0 (MSB of 8'h0F), and hvalid is never set.
- **LSB-first.**
  - Stimulus: MSB_FIRST=0, accept 8'h01.
  - Response: out = 1,0,0,0,0,0,0,0.
- **Reset mid-operation.**
  - Stimulus: accept 8'hFF, assert reset after 3 bits while hbuf holds 8'hAA.
  - Response: the cycle after reset, out = 0, out_valid = 0, busy = 0, load_ready = 1. No bit of 8'hAA is ever emitted.
- **Integration with the detector.**
  - Stimulus: serialize 8'h0A (MSB-first: 0,0,0,0,1,0,1,0).
  - Response: the detector output pulses high exactly once, in the cycle the final 0 is presented.
